// File: rtl/mod_inv.sv
// -----------------------------------------------------------------------------
// mod_inv: sequential modular inverter, R = A^-1 mod P, using the binary
// extended-Euclid algorithm with one reduction step per clock.
//
// Ports:
//   clk        in   clock, all logic on the rising edge
//   rst        in   synchronous active-high reset
//   start      in   one-cycle request, only looked at while idle
//   A          in   WIDTH-bit operand, captured on the accepting edge
//   R          out  WIDTH-bit result, held until the next done
//   done       out  one-cycle pulse, R/err valid in that cycle
//   busy       out  high from the cycle after start is accepted up to and
//                   including the done cycle
//   err        out  valid with done; 1 when A mod P == 0 (no inverse)
//   cycle_cnt  out  11-bit count of ITER cycles of the last operation,
//                   present only when MOD_INV_CYCLE_CNT_EN is defined
//
// Handshake: there is no back-pressure. start is a request that is accepted
// only when busy is low; start while busy is dropped, not queued. done is a
// single-cycle completion strobe with no ready: the consumer must capture
// R/err in that cycle (they also stay stable until the next done).
//
// Optional feature macro: MOD_INV_CYCLE_CNT_EN (adds the cycle_cnt port).
// -----------------------------------------------------------------------------
module mod_inv #(
    parameter int unsigned      WIDTH = 256,
    parameter logic [WIDTH-1:0] P     = 256'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEFFFFFC2F
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] R,
    output logic             done,
    output logic             busy,
    output logic             err
`ifdef MOD_INV_CYCLE_CNT_EN
    ,
    output logic [10:0]      cycle_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        ITER = 2'd2,
        FIN  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q,  a_d;
    logic [WIDTH-1:0] u_q,  u_d;
    logic [WIDTH-1:0] v_q,  v_d;
    logic [WIDTH-1:0] x1_q, x1_d;
    logic [WIDTH-1:0] x2_q, x2_d;
    logic [WIDTH-1:0] r_q,  r_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;
    logic             err_q,  err_d;
    logic [WIDTH-1:0] a_red;
`ifdef MOD_INV_CYCLE_CNT_EN
    logic [10:0]      cnt_q, cnt_d;
`endif

    // x/2 mod P for x in [0,P). An odd x is made even by adding P first; the
    // sum is formed one bit wider so the carry out of bit WIDTH-1 survives.
    function automatic logic [WIDTH-1:0] half_mod(input logic [WIDTH-1:0] x);
        logic [WIDTH:0] s;
        if (x[0]) begin
            s = {1'b0, x} + {1'b0, P};
        end else begin
            s = {1'b0, x};
        end
        return s[WIDTH:1];
    endfunction

    // (a - b) mod P for a, b in [0,P). When a < b the WIDTH-bit wrap of a-b
    // plus P lands back in [1,P), so no extra bit is needed.
    function automatic logic [WIDTH-1:0] sub_mod(input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
        if (a >= b) begin
            return a - b;
        end else begin
            return a - b + P;
        end
    endfunction

    // A < 2^WIDTH < 2P, so a single conditional subtraction fully reduces it.
    assign a_red = (a_q >= P) ? (a_q - P) : a_q;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        u_d     = u_q;
        v_d     = v_q;
        x1_d    = x1_q;
        x2_d    = x2_q;
        r_d     = r_q;
        done_d  = 1'b0;
        busy_d  = busy_q;
        err_d   = err_q;
`ifdef MOD_INV_CYCLE_CNT_EN
        cnt_d   = cnt_q;
`endif

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = A;
                    busy_d  = 1'b1;
                    state_d = LOAD;
                end
            end

            LOAD: begin
                u_d  = a_red;
                v_d  = P;
                x1_d = WIDTH'(1);
                x2_d = '0;
`ifdef MOD_INV_CYCLE_CNT_EN
                cnt_d = '0;
`endif
                if (a_red == '0) begin
                    // No inverse: the FIN cycle reports err with R=0.
                    r_d     = '0;
                    err_d   = 1'b1;
                    done_d  = 1'b1;
                    state_d = FIN;
                end else begin
                    state_d = ITER;
                end
            end

            ITER: begin
`ifdef MOD_INV_CYCLE_CNT_EN
                if (cnt_q != 11'h7FF) begin
                    cnt_d = cnt_q + 11'd1;
                end
`endif
                if ((u_q == WIDTH'(1)) || (v_q == WIDTH'(1))) begin
                    // Result is registered on the way into FIN so that done,
                    // R and err all become visible in the FIN cycle.
                    r_d     = (u_q == WIDTH'(1)) ? x1_q : x2_q;
                    err_d   = 1'b0;
                    done_d  = 1'b1;
                    state_d = FIN;
                end else if (!u_q[0]) begin
                    u_d  = u_q >> 1;
                    x1_d = half_mod(x1_q);
                end else if (!v_q[0]) begin
                    v_d  = v_q >> 1;
                    x2_d = half_mod(x2_q);
                end else if (u_q >= v_q) begin
                    u_d  = u_q - v_q;
                    x1_d = sub_mod(x1_q, x2_q);
                end else begin
                    v_d  = v_q - u_q;
                    x2_d = sub_mod(x2_q, x1_q);
                end
            end

            FIN: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            u_q     <= '0;
            v_q     <= '0;
            x1_q    <= '0;
            x2_q    <= '0;
            r_q     <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
`ifdef MOD_INV_CYCLE_CNT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            u_q     <= u_d;
            v_q     <= v_d;
            x1_q    <= x1_d;
            x2_q    <= x2_d;
            r_q     <= r_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
`ifdef MOD_INV_CYCLE_CNT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    assign R    = r_q;
    assign done = done_q;
    assign busy = busy_q;
    assign err  = err_q;
`ifdef MOD_INV_CYCLE_CNT_EN
    assign cycle_cnt = cnt_q;
`endif

endmodule
